// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive controller: interrupt ID codes,
// trigger thresholds, read-sequencer states and line-status bit positions.
package uart_rx_pkg;

  localparam logic [3:0] IID_NONE    = 4'b0001;
  localparam logic [3:0] IID_LINE    = 4'b0110;
  localparam logic [3:0] IID_DATA    = 4'b0100;
  localparam logic [3:0] IID_TIMEOUT = 4'b1100;

  localparam logic [4:0] TRIG_1  = 5'd1;
  localparam logic [4:0] TRIG_4  = 5'd4;
  localparam logic [4:0] TRIG_8  = 5'd8;
  localparam logic [4:0] TRIG_14 = 5'd14;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_SETTLE = 2'd2
  } rd_state_t;

  localparam int LSR_DR      = 0;
  localparam int LSR_OE      = 1;
  localparam int LSR_PE      = 2;
  localparam int LSR_FE      = 3;
  localparam int LSR_BI      = 4;
  localparam int LSR_FIFOERR = 7;

  function automatic logic [4:0] trig_threshold(input logic [1:0] level);
    case (level)
      2'b00:   trig_threshold = TRIG_1;
      2'b01:   trig_threshold = TRIG_4;
      2'b10:   trig_threshold = TRIG_8;
      default: trig_threshold = TRIG_14;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_timeout.sv
// Character-timeout tracker: counts idle character times while the FIFO
// holds data and flags a pending timeout once TIMEOUT_CHARS have elapsed.
module uart_rx_timeout #(
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic fifoWe,
  input  logic fifoRe,
  input  logic fifoEmpty,
  input  logic charTick,
  output logic timeoutPending
);

  localparam logic [2:0] LP_LIMIT = 3'(TIMEOUT_CHARS);

  logic [2:0] r_count;
  logic [2:0] w_count_next;
  logic       r_pending;
  logic       w_pending_next;

  always_comb begin
    w_count_next = r_count;
    if (fifoWe || fifoRe || fifoEmpty)
      w_count_next = 3'd0;
    else if (charTick && (r_count != LP_LIMIT))
      w_count_next = r_count + 3'd1;
  end

  // Exported from the next-state value so the interrupt register can
  // react in the same edge that completes the final character time.
  assign w_pending_next = !(fifoRe || fifoEmpty) &&
                          (r_pending || (w_count_next == LP_LIMIT));
  assign timeoutPending = w_pending_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count   <= 3'd0;
      r_pending <= 1'b0;
    end else begin
      r_count   <= w_count_next;
      r_pending <= w_pending_next;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: FIFO pop sequencing, line status and the
// prioritised receive interrupt. Macro UART_RX_TIMEOUT_EN builds the timeout source.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fifoWe,
  input  logic       fifoFull,
  input  logic       fifoEmpty,
  input  logic [4:0] nrOfEntries,
  input  logic       frameErrorIn,
  input  logic       parityErrorIn,
  input  logic       breakIn,
  input  logic       fifoError,
  input  logic       charTick,
  input  logic [1:0] triggerLevel,
  input  logic       enableDataInt,
  input  logic       enableLineInt,
  input  logic       readData,
  input  logic       readLsr,
  output logic       fifoRe,
  output logic       clearError,
  output logic [7:0] lsr,
  output logic       irq,
  output logic [3:0] irqId
);

  rd_state_t r_state;
  rd_state_t w_state_next;
  logic      w_fifo_re;

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_fifo_re    = 1'b0;
    case (r_state)
      ST_IDLE:   if (readData && !fifoEmpty) w_state_next = ST_POP;
      ST_POP: begin
        w_fifo_re    = 1'b1;
        w_state_next = ST_SETTLE;
      end
      ST_SETTLE: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  assign fifoRe = w_fifo_re;

  logic w_timeout_pending;
`ifdef UART_RX_TIMEOUT_EN
  uart_rx_timeout #(.TIMEOUT_CHARS(TIMEOUT_CHARS)) u_timeout (
    .clock          (clock),
    .reset          (reset),
    .fifoWe         (fifoWe),
    .fifoRe         (w_fifo_re),
    .fifoEmpty      (fifoEmpty),
    .charTick       (charTick),
    .timeoutPending (w_timeout_pending)
  );
`else
  // No timeout source: the tick and parameter are referenced but masked off.
  assign w_timeout_pending = 1'b0 & charTick & (TIMEOUT_CHARS > 0);
`endif

  logic r_dr, r_oe, r_pe, r_fe, r_bi, r_fifo_err, r_clear_error, r_irq;
  logic [3:0] r_irq_id;
  logic w_oe_next, w_pe_next, w_fe_next, w_bi_next;
  logic [3:0] w_irq_id_next;

  // A new error in the same cycle as the status read survives the clear.
  assign w_oe_next = (fifoWe && fifoFull && !w_fifo_re) || (r_oe && !readLsr);
  assign w_pe_next = (parityErrorIn && !fifoEmpty) || (r_pe && !readLsr);
  assign w_fe_next = (frameErrorIn && !fifoEmpty) || (r_fe && !readLsr);
  assign w_bi_next = (breakIn && !fifoEmpty) || (r_bi && !readLsr);

  always_comb begin
    w_irq_id_next = IID_NONE;
    if (enableLineInt && (w_oe_next || w_pe_next || w_fe_next || w_bi_next))
      w_irq_id_next = IID_LINE;
    else if (enableDataInt && (nrOfEntries >= trig_threshold(triggerLevel)))
      w_irq_id_next = IID_DATA;
    else if (enableDataInt && w_timeout_pending)
      w_irq_id_next = IID_TIMEOUT;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_dr          <= 1'b0;
      r_oe          <= 1'b0;
      r_pe          <= 1'b0;
      r_fe          <= 1'b0;
      r_bi          <= 1'b0;
      r_fifo_err    <= 1'b0;
      r_clear_error <= 1'b0;
      r_irq         <= 1'b0;
      r_irq_id      <= IID_NONE;
    end else begin
      r_dr          <= !fifoEmpty;
      r_oe          <= w_oe_next;
      r_pe          <= w_pe_next;
      r_fe          <= w_fe_next;
      r_bi          <= w_bi_next;
      r_fifo_err    <= fifoError;
      r_clear_error <= readLsr;
      r_irq         <= (w_irq_id_next != IID_NONE);
      r_irq_id      <= w_irq_id_next;
    end
  end

  always_comb begin
    lsr              = 8'h00;
    lsr[LSR_DR]      = r_dr;
    lsr[LSR_OE]      = r_oe;
    lsr[LSR_PE]      = r_pe;
    lsr[LSR_FE]      = r_fe;
    lsr[LSR_BI]      = r_bi;
    lsr[LSR_FIFOERR] = r_fifo_err;
  end

  assign clearError = r_clear_error;
  assign irq        = r_irq;
  assign irqId      = r_irq_id;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: a simple FIFO environment, a
// behavioural reference model checked every cycle, and directed literal checks.
module tb_uart_rx_ctrl;

  localparam int TO = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       fifoWe = 1'b0, fifoFull = 1'b0, fifoEmpty = 1'b1;
  logic [4:0] nrOfEntries = 5'd0;
  logic       frameErrorIn = 1'b0, parityErrorIn = 1'b0, breakIn = 1'b0;
  logic       fifoError = 1'b0, charTick = 1'b0;
  logic [1:0] triggerLevel = 2'b00;
  logic       enableDataInt = 1'b0, enableLineInt = 1'b0;
  logic       readData = 1'b0, readLsr = 1'b0;
  logic       fifoRe, clearError, irq;
  logic [7:0] lsr;
  logic [3:0] irqId;

  always #5 clock = ~clock;

  uart_rx_ctrl #(.TIMEOUT_CHARS(TO)) dut (
    .clock(clock), .reset(reset), .fifoWe(fifoWe), .fifoFull(fifoFull),
    .fifoEmpty(fifoEmpty), .nrOfEntries(nrOfEntries),
    .frameErrorIn(frameErrorIn), .parityErrorIn(parityErrorIn),
    .breakIn(breakIn), .fifoError(fifoError), .charTick(charTick),
    .triggerLevel(triggerLevel), .enableDataInt(enableDataInt),
    .enableLineInt(enableLineInt), .readData(readData), .readLsr(readLsr),
    .fifoRe(fifoRe), .clearError(clearError), .lsr(lsr), .irq(irq),
    .irqId(irqId)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int env_cnt  = 0;
  int thr[4]   = '{1, 4, 8, 14};

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [3:0] EXP_TO_IID = 4'b1100;
`else
  localparam logic [3:0] EXP_TO_IID = 4'b0001;
`endif

  // Reference model state: what the outputs must show in the current cycle.
  bit         m_valid = 0;
  int         m_busy  = 0;
  int         m_ticks = 0;
  bit         m_pop = 0, m_clr = 0, m_pend = 0;
  bit         m_dr = 0, m_oe = 0, m_pe = 0, m_fe = 0, m_bi = 0, m_b7 = 0;
  logic [3:0] m_iid = 4'b0001;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_step();
    bit pop_now;
    bit accept;
    pop_now = m_pop;
    if (reset) begin
      m_busy = 0; m_ticks = 0; m_pop = 0; m_clr = 0; m_pend = 0;
      m_dr = 0; m_oe = 0; m_pe = 0; m_fe = 0; m_bi = 0; m_b7 = 0;
      m_iid = 4'b0001;
      m_valid = 1;
    end else begin
      accept = readData && !fifoEmpty && (m_busy == 0);
      if (m_busy > 0) m_busy--;
      else if (accept) m_busy = 2;
      m_pop = accept;
      m_clr = readLsr;
      m_oe = (fifoWe && fifoFull && !pop_now) || (m_oe && !readLsr);
      m_pe = (parityErrorIn && !fifoEmpty) || (m_pe && !readLsr);
      m_fe = (frameErrorIn && !fifoEmpty) || (m_fe && !readLsr);
      m_bi = (breakIn && !fifoEmpty) || (m_bi && !readLsr);
      m_dr = !fifoEmpty;
      m_b7 = fifoError;
      if (fifoEmpty || fifoWe || pop_now) m_ticks = 0;
      else if (charTick) m_ticks++;
`ifdef UART_RX_TIMEOUT_EN
      m_pend = !(pop_now || fifoEmpty) && (m_pend || (m_ticks >= TO));
`else
      m_pend = 0;
`endif
      if (enableLineInt && (m_oe || m_pe || m_fe || m_bi)) m_iid = 4'b0110;
      else if (enableDataInt && (int'(nrOfEntries) >= thr[triggerLevel])) m_iid = 4'b0100;
      else if (enableDataInt && m_pend) m_iid = 4'b1100;
      else m_iid = 4'b0001;
    end
  endtask

  // One clock cycle: drive FIFO flags, compare against the model, advance.
  task automatic cyc();
    bit saw_re;
    fifoEmpty   = (env_cnt == 0);
    fifoFull    = (env_cnt == 16);
    nrOfEntries = 5'(env_cnt);
    #1;
    if (m_valid) begin
      chk("fifoRe", {7'b0, fifoRe}, {7'b0, m_pop});
      chk("clearError", {7'b0, clearError}, {7'b0, m_clr});
      chk("lsr", lsr, {m_b7, 2'b00, m_bi, m_fe, m_pe, m_oe, m_dr});
      chk("irqId", {4'b0, irqId}, {4'b0, m_iid});
      chk("irq", {7'b0, irq}, {7'b0, (m_iid != 4'b0001)});
    end
    saw_re = fifoRe;
    model_step();
    @(posedge clock);
    #1;
    if (fifoWe && env_cnt < 16) env_cnt++;
    if (saw_re && env_cnt > 0) env_cnt--;
    fifoWe = 0; readData = 0; readLsr = 0; charTick = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic write(input int n);
    for (int i = 0; i < n; i++) begin
      fifoWe = 1;
      cyc();
    end
  endtask

  initial begin
    @(posedge clock);
    #1;
    reset = 1;
    idle(2);
    chk("reset_lsr", lsr, 8'h00);
    chk("reset_irqId", {4'b0, irqId}, 8'h01);
    chk("reset_irq", {7'b0, irq}, 8'h00);
    reset = 0;
    idle(1);

    // Data available at trigger level 4
    triggerLevel = 2'b01; enableDataInt = 1;
    write(3); idle(2);
    chk("data_below_trig", {7'b0, irq}, 8'h00);
    write(1); idle(2);
    chk("data_at_trig_id", {4'b0, irqId}, 8'h04);
    chk("data_at_trig_irq", {7'b0, irq}, 8'h01);

    // Read sequencing with a dropped back-to-back read
    readData = 1; cyc();
    chk("pop_next_cycle", {7'b0, fifoRe}, 8'h01);
    readData = 1; cyc();
    idle(2);
    chk("dr_after_one_pop", {7'b0, lsr[0]}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      readData = 1; cyc(); idle(2);
    end
    idle(1);
    chk("dr_after_drain", {7'b0, lsr[0]}, 8'h00);

    // Read of an empty FIFO
    readData = 1; cyc(); idle(1);
    chk("empty_read_lsr", lsr, 8'h00);
    chk("empty_read_irq", {7'b0, irq}, 8'h00);

    // Parity error takes priority over data available
    triggerLevel = 2'b00; enableLineInt = 1;
    write(1);
    parityErrorIn = 1; fifoError = 1;
    idle(2);
    chk("pe_set", {7'b0, lsr[2]}, 8'h01);
    chk("line_prio_id", {4'b0, irqId}, 8'h06);
    chk("fifoerr_bit7", {7'b0, lsr[7]}, 8'h01);
    parityErrorIn = 0; fifoError = 0;
    readLsr = 1; cyc();
    chk("clear_error_pulse", {7'b0, clearError}, 8'h01);
    idle(1);
    chk("pe_cleared", {7'b0, lsr[2]}, 8'h00);
    chk("data_after_clear_id", {4'b0, irqId}, 8'h04);

    // Overrun, including a status read colliding with a new overrun
    write(15);
    fifoWe = 1; cyc();
    chk("oe_set", {7'b0, lsr[1]}, 8'h01);
    fifoWe = 1; readLsr = 1; cyc();
    chk("oe_set_wins", {7'b0, lsr[1]}, 8'h01);
    readLsr = 1; cyc();
    chk("oe_cleared", {7'b0, lsr[1]}, 8'h00);

    // Reset in the middle of a read sequence
    readData = 1; cyc();
    chk("pop_before_reset", {7'b0, fifoRe}, 8'h01);
    reset = 1; cyc(); cyc();
    reset = 0; env_cnt = 0;
    idle(3);
    chk("no_pop_after_reset", {7'b0, fifoRe}, 8'h00);

    // Character timeout with one entry below the trigger level of 8
    triggerLevel = 2'b10; enableDataInt = 1; enableLineInt = 1;
    write(1); idle(2);
    for (int i = 0; i < TO - 1; i++) begin
      charTick = 1; cyc(); idle(1);
    end
    chk("timeout_not_yet", {7'b0, irq}, 8'h00);
    charTick = 1; cyc();
    chk("timeout_id", {4'b0, irqId}, {4'b0, EXP_TO_IID});
    idle(1);
    readData = 1; cyc(); idle(2);
    chk("timeout_cleared", {7'b0, irq}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART block. It sits between the CPU register interface and the 16-entry receive FIFO. It sequences FIFO pops on receive-buffer reads, clears per-entry error flags on line-status reads, and maintains the line-status bits. It also generates a prioritised receive interrupt from three sources: line status, data available at the trigger level, and character timeout.

## Interface
Parameters:
- TIMEOUT_CHARS, 4: character times of inactivity, with a non-empty FIFO, before a timeout interrupt; legal range 1..7.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fifoWe  in  1  FIFO write strobe from the receiver
- fifoFull  in  1  FIFO full flag
- fifoEmpty  in  1  FIFO empty flag
- nrOfEntries  in  5  FIFO occupancy, 0..16
- frameErrorIn, parityErrorIn, breakIn  in  1  error flags of the FIFO head entry
- fifoError  in  1  an error flag is present anywhere in the FIFO
- charTick  in  1  one-cycle pulse per character time, from the baud generator
- triggerLevel  in  2  data-available threshold: 00→1, 01→4, 10→8, 11→14
- enableDataInt, enableLineInt  in  1  interrupt enables; enableDataInt also gates the timeout interrupt
- readData  in  1  one-cycle CPU read strobe of the receive buffer register
- readLsr  in  1  one-cycle CPU read strobe of the line status register
- fifoRe  out  1  FIFO pop strobe
- clearError  out  1  clears the error flags of the FIFO head entry
- lsr  out  8  line status: [0] DR, [1] OE, [2] PE, [3] FE, [4] BI, [6:5] 0, [7] fifoError
- irq  out  1  receive interrupt request
- irqId  out  4  interrupt identification code

## Operation
Read sequencer FSM, with states IDLE, POP and SETTLE:
- IDLE: on `readData` with `fifoEmpty`=0, go to POP. On `readData` with `fifoEmpty`=1, no action.
- POP: `fifoRe`=1 for exactly one cycle, then go to SETTLE.
- SETTLE: wait one cycle for the head flags to update, then go to IDLE.
- `readData` received in POP or SETTLE is dropped. There is never more than one pop per three cycles.

Line status:
- DR = ~`fifoEmpty`, registered.
- OE is sticky. It is set when `fifoWe` & `fifoFull` & ~`fifoRe`.
- PE, FE and BI are sticky. Each is set when the matching head flag is 1 while `fifoEmpty`=0.
- `readLsr` clears OE, PE, FE and BI, and pulses `clearError` for one cycle.
- If a set and a clear of the same bit occur in the same cycle, the set wins.
- bit7 follows `fifoError`, registered.

Character timeout:
- A 3-bit counter increments on `charTick` and saturates at TIMEOUT_CHARS.
- It resets to 0 on `fifoWe`, on `fifoRe`, or while `fifoEmpty`=1.
- `timeoutPending` is set when the counter equals TIMEOUT_CHARS and `fifoEmpty`=0.
- `timeoutPending` is cleared by `fifoRe` or when `fifoEmpty`=1.

Interrupt priority (highest first), evaluated every cycle:
- Line status: `enableLineInt` & (OE|PE|FE|BI). `irqId`=4'b0110.
- Data available: `enableDataInt` & (`nrOfEntries` ≥ threshold). `irqId`=4'b0100.
- Timeout: `enableDataInt` & `timeoutPending`. `irqId`=4'b1100.
- None of the above: `irqId`=4'b0001, `irq`=0.
- `irq` = (`irqId` ≠ 4'b0001).

Arithmetic: compare `nrOfEntries` against a 5-bit threshold, zero-extended. 16 entries satisfies every trigger level.

## Timing
- Reset values: `fifoRe`=0, `clearError`=0, `lsr`=8'h00, `irq`=0, `irqId`=4'b0001; FSM in IDLE; timeout counter 0; all sticky bits 0.
- Reset asserted mid-sequence returns the FSM to IDLE on the next edge. No further `fifoRe` is issued.
- `fifoRe` is asserted on the cycle after the `readData` edge.
- `clearError` is asserted on the cycle after the `readLsr` edge.
- `lsr`, `irq` and `irqId` are registered. They reflect their inputs with one cycle of latency.
- Timeout: `irq` rises one cycle after the TIMEOUT_CHARS-th `charTick`.

## Configuration
Macro `UART_RX_TIMEOUT_EN`:
- Defined: the timeout counter and `timeoutPending` are built, and code 4'b1100 can be produced.
- Undefined: no counter is built, `timeoutPending` is tied to 0, `charTick` is ignored, and 4'b1100 is never produced.

## Structure
Package `uart_rx_pkg` holds:
- the IIR codes (IID_NONE, IID_LINE, IID_DATA, IID_TIMEOUT);
- the trigger-threshold constants (1, 4, 8, 14);
- the FSM state encoding;
- the LSR bit indices.

One sub-module, `uart_rx_timeout`, contains the counter and `timeoutPending`. It is instantiated only under `UART_RX_TIMEOUT_EN`.

## Test plan
- Data available: `triggerLevel`=01, `enableDataInt`=1, write 3 entries → `irq`=0. Write a 4th → `irq`=1, `irqId`=4'b0100 one cycle later.
- Read sequencing: `readData` with 2 entries → single-cycle `fifoRe` on cycle +1. `readData` at cycle +1 is dropped. DR stays 1 until the second pop.
- Empty read: `readData` with `fifoEmpty`=1 → no `fifoRe`; `lsr` and `irq` unchanged.
- Line status: head `parityErrorIn`=1, `enableLineInt`=1 → `lsr`[2]=1, `irqId`=4'b0110 (priority over data). `readLsr` → `clearError` pulse; `lsr`[2]=0.
- Overrun: FIFO full and `fifoWe`=1 → `lsr`[1]=1. Simultaneous `readLsr` and new overrun → OE stays 1.
- Timeout (macro defined, TIMEOUT_CHARS=4): 1 entry, `triggerLevel`=10, 4 `charTick` pulses → `irqId`=4'b1100. `readData` → `irq`=0.
